symbol_generator: RTL

SYMBOL_GENERATOR -- requirements
Module: symbol_generator

---
 rtl/symbol_generator.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/symbol_generator.sv
// ---------------------------------------------------------------------------
// symbol_generator
//
// Purpose: paces the game by presenting pseudo-random 3-bit symbols at a
// programmable period. A 32-bit divider sets the emission period. A 16-bit
// Galois LFSR supplies the symbols. A small FSM tracks the following:
//   - whether a symbol is still waiting for the consumer;
//   - how many symbols have been emitted this level;
//   - when the level is complete.
//
// Ports:
//   Clk100M    in   1  100 MHz clock, all registers update on rising edge
//   rstN       in   1  synchronous active-low reset
//   enable     in   1  game running; low drops back to IDLE
//   symGenMax  in  32  requested emission period in clocks
//   newLevel   in   1  one-cycle pulse, restarts the level
//   symAck     in   1  consumer accepts the presented symbol
//   symbol     out  3  presented symbol code
//   symValid   out  1  symbol valid and awaiting acknowledge
//   symCount   out  8  symbols emitted in the current level
//   levelDone  out  1  one-cycle pulse, drives the level controller's incLevel
//   overrun    out  1  one-cycle pulse, period expired with a symbol unacked
// ---------------------------------------------------------------------------
module symbol_generator #(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter logic [7:0]  SYMS_PER_LEVEL = 8'd10,
  parameter logic [31:0] MIN_PERIOD     = 32'd1000
) (
  input  logic        Clk100M,
  input  logic        rstN,
  input  logic        enable,
  input  logic [31:0] symGenMax,
  input  logic        newLevel,
  input  logic        symAck,
  output logic [2:0]  symbol,
  output logic        symValid,
  output logic [7:0]  symCount,
  output logic        levelDone,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PEND    = 2'd2,
    WAITLVL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] divCnt_q, divCnt_d;
  logic [31:0] period_q, period_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  symbol_q, symbol_d;
  logic        symValid_q, symValid_d;
  logic [7:0]  symCount_q, symCount_d;
  logic        levelDone_q, levelDone_d;
  logic        overrun_q, overrun_d;

  logic [31:0] clampedPeriod;
  logic        expiry;
  logic [15:0] lfsrNext;
  logic        atLimit;

  // Requests faster than MIN_PERIOD are clamped so the player always gets
  // at least MIN_PERIOD clocks per symbol.
  assign clampedPeriod = (symGenMax < MIN_PERIOD) ? MIN_PERIOD : symGenMax;

  // The divider expires on its last count. period_q is never below
  // MIN_PERIOD, so period_q - 1 does not underflow.
  assign expiry = (divCnt_q == (period_q - 32'd1));

  // Right-shifting Galois LFSR. The taps are applied when a 1 falls out of
  // the bottom bit.
  assign lfsrNext = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  assign atLimit = (symCount_q >= SYMS_PER_LEVEL);

  // Next-state logic. The divider runs only in RUN and PEND. It reloads the
  // period on every wrap, so a symGenMax change only affects the next
  // interval. newLevel is checked before anything else, so it wins over
  // expiry and symAck in the same cycle.
  always_comb begin
    state_d     = state_q;
    divCnt_d    = divCnt_q;
    period_d    = period_q;
    lfsr_d      = lfsr_q;
    symbol_d    = symbol_q;
    symValid_d  = symValid_q;
    symCount_d  = symCount_q;
    levelDone_d = 1'b0;
    overrun_d   = 1'b0;

    if (newLevel) begin
      symCount_d = 8'd0;
      divCnt_d   = 32'd0;
      symValid_d = 1'b0;
      period_d   = clampedPeriod;
      state_d    = enable ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          symValid_d = 1'b0;
          divCnt_d   = 32'd0;
          if (enable) begin
            period_d = clampedPeriod;
            state_d  = RUN;
          end
        end

        RUN: begin
          if (!enable) begin
            symValid_d = 1'b0;
            divCnt_d   = 32'd0;
            state_d    = IDLE;
          end else if (expiry) begin
            divCnt_d = 32'd0;
            period_d = clampedPeriod;
            if (atLimit) begin
              // The level's last symbol was abandoned by an enable drop
              // before its ack. Close the level here so the count stays
              // capped and the level controller still hears about it.
              levelDone_d = 1'b1;
              state_d     = WAITLVL;
            end else begin
              lfsr_d     = lfsrNext;
              symbol_d   = lfsrNext[2:0];
              symValid_d = 1'b1;
              symCount_d = symCount_q + 8'd1;
              state_d    = PEND;
            end
          end else begin
            divCnt_d = divCnt_q + 32'd1;
          end
        end

        PEND: begin
          if (!enable) begin
            symValid_d = 1'b0;
            divCnt_d   = 32'd0;
            state_d    = IDLE;
          end else begin
            if (expiry) begin
              divCnt_d = 32'd0;
              period_d = clampedPeriod;
            end else begin
              divCnt_d = divCnt_q + 32'd1;
            end

            if (symAck) begin
              if (atLimit) begin
                levelDone_d = 1'b1;
                symValid_d  = 1'b0;
                divCnt_d    = 32'd0;
                state_d     = WAITLVL;
              end else if (expiry) begin
                // The ack retires the old symbol while the expiry presents
                // the next one on the same edge. symValid stays high.
                lfsr_d     = lfsrNext;
                symbol_d   = lfsrNext[2:0];
                symValid_d = 1'b1;
                symCount_d = symCount_q + 8'd1;
              end else begin
                symValid_d = 1'b0;
                state_d    = RUN;
              end
            end else if (expiry) begin
              overrun_d = 1'b1;
            end
          end
        end

        WAITLVL: begin
          symValid_d = 1'b0;
          divCnt_d   = 32'd0;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers. Reset is synchronous and overrides every
  // other input.
  always_ff @(posedge Clk100M) begin
    if (!rstN) begin
      state_q     <= IDLE;
      divCnt_q    <= 32'd0;
      period_q    <= MIN_PERIOD;
      lfsr_q      <= LFSR_SEED;
      symbol_q    <= 3'd0;
      symValid_q  <= 1'b0;
      symCount_q  <= 8'd0;
      levelDone_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      divCnt_q    <= divCnt_d;
      period_q    <= period_d;
      lfsr_q      <= lfsr_d;
      symbol_q    <= symbol_d;
      symValid_q  <= symValid_d;
      symCount_q  <= symCount_d;
      levelDone_q <= levelDone_d;
      overrun_q   <= overrun_d;
    end
  end

  assign symbol    = symbol_q;
  assign symValid  = symValid_q;
  assign symCount  = symCount_q;
  assign levelDone = levelDone_q;
  assign overrun   = overrun_q;

endmodule
